// File: rtl/driver.sv
// VGA output stage: 640x480@60 timing from a divided system clock, synthetic
// test pattern with a rectangular mask window; pixels outside it are dimmed.
module driver #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MASK_X0  = 160,
    parameter int MASK_X1  = 479,
    parameter int MASK_Y0  = 120,
    parameter int MASK_Y1  = 359
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       vga_vs,
    output logic       vga_hs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least 8 bits wide so the pattern nibble [7:4] always exists.
    localparam int HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int VW = ($clog2(V_TOTAL) < 8) ? 8 : $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] MX0      = HW'(MASK_X0);
    localparam logic [HW-1:0] MX1      = HW'(MASK_X1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] MY0      = VW'(MASK_Y0);
    localparam logic [VW-1:0] MY1      = VW'(MASK_Y1);

    function automatic logic [3:0] dim_quarter(input logic [3:0] c);
        return {2'b00, c[3:2]};
    endfunction

    logic          pix_en;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
            logic [DW-1:0] div_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt <= '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign pix_en = (div_cnt == DIV_LAST);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Stage p0: combinational sync, blanking, pattern and mask from current counters
    logic        hs_p0, vs_p0, active_p0, inside_p0;
    logic [3:0]  pr_p0, pg_p0, pb_p0;
    logic [11:0] rgb_p0;

    always_comb begin
        hs_p0     = !((hcnt >= HS_START) && (hcnt < HS_END));
        vs_p0     = !((vcnt >= VS_START) && (vcnt < VS_END));
        active_p0 = (hcnt < H_VIS) && (vcnt < V_VIS);
        inside_p0 = (hcnt >= MX0) && (hcnt <= MX1) && (vcnt >= MY0) && (vcnt <= MY1);
        pr_p0     = hcnt[7:4];
        pg_p0     = vcnt[7:4];
        pb_p0     = hcnt[7:4] ^ vcnt[7:4];
        rgb_p0    = 12'h000;
        if (active_p0) begin
            if (inside_p0) begin
                rgb_p0 = {pr_p0, pg_p0, pb_p0};
            end else begin
                rgb_p0 = {dim_quarter(pr_p0), dim_quarter(pg_p0), dim_quarter(pb_p0)};
            end
        end
    end

    // Stage p1: output registers, one pixel period behind the counters
    logic        hs_p1, vs_p1;
    logic [11:0] rgb_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            rgb_p1 <= 12'h000;
        end else if (pix_en) begin
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            rgb_p1 <= rgb_p0;
        end
    end

    assign vga_hs = hs_p1;
    assign vga_vs = vs_p1;
    assign vga_r  = rgb_p1[11:8];
    assign vga_g  = rgb_p1[7:4];
    assign vga_b  = rgb_p1[3:0];

endmodule

// File: tb/tb_driver.sv
// Bench for driver on a scaled-down raster (240x40 total, divide-by-2) so whole
// frames fit in a short run; outputs are checked against an arithmetic raster model.
module tb_driver;

    localparam int CD  = 2;
    localparam int HA  = 200;
    localparam int HF  = 8;
    localparam int HSY = 16;
    localparam int HB  = 16;
    localparam int VA  = 32;
    localparam int VF  = 2;
    localparam int VSY = 3;
    localparam int VB  = 3;
    localparam int MX0 = 40;
    localparam int MX1 = 159;
    localparam int MY0 = 8;
    localparam int MY1 = 23;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam logic [13:0] RST_OUT = 14'h3000;

    logic       clk;
    logic       rst_n;
    logic       vga_vs, vga_hs;
    logic [3:0] vga_r, vga_g, vga_b;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned ecnt;

    driver #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .MASK_X0(MX0), .MASK_X1(MX1), .MASK_Y0(MY0), .MASK_Y1(MY1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs), .vga_hs(vga_hs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    function automatic logic [13:0] obs();
        return {vga_hs, vga_vs, vga_r, vga_g, vga_b};
    endfunction

    // Output expected after e clock edges: update k lands at edge k*CD and shows pixel k-1.
    function automatic logic [13:0] model_at(input int unsigned e);
        int unsigned idx, x, y, r, g, b;
        logic hs, vs;
        if (e < CD) return RST_OUT;
        idx = e / CD - 1;
        x   = idx % HT;
        y   = (idx / HT) % VT;
        hs  = !(x >= HA + HF && x < HA + HF + HSY);
        vs  = !(y >= VA + VF && y < VA + VF + VSY);
        r = 0; g = 0; b = 0;
        if (x < HA && y < VA) begin
            r = (x / 16) % 16;
            g = (y / 16) % 16;
            b = r ^ g;
            if (!(x >= MX0 && x <= MX1 && y >= MY0 && y <= MY1)) begin
                r = r / 4; g = g / 4; b = b / 4;
            end
        end
        return {hs, vs, r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_compare(input int n, input string tag);
        logic [13:0] exp_v;
        for (int i = 0; i < n; i++) begin
            step();
            exp_v = model_at(ecnt);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL %s edge=%0d got=%h want=%h", tag, ecnt, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs() !== RST_OUT) begin
                n_bad++;
                $display("FAIL reset_hold got=%h want=%h", obs(), RST_OUT);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_compare(CD + 4, "reset_release");
    endtask

    task automatic test_fixed_pixels();
        int unsigned px[6]  = '{199, 200, 1410, 4900, 6900, 8405};
        logic [13:0] want[6] = '{14'h3303, 14'h3000, 14'h1000, 14'h3617, 14'h3202, 14'h2000};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            int guard = 0;
            while (ecnt != (px[k] + 1) * CD && guard < 20000) begin
                step();
                guard++;
            end
            n_cmp++;
            if (obs() !== want[k] || ecnt != (px[k] + 1) * CD) begin
                n_bad++;
                $display("FAIL fixed_pixel idx=%0d got=%h want=%h", px[k], obs(), want[k]);
            end
        end
    endtask

    task automatic test_line_timing();
        int guard;
        int unsigned t_fall, t_rise;
        do_reset();
        guard = 0;
        while (vga_hs !== 1'b0 && guard < 2000) begin step(); guard++; end
        t_fall = ecnt;
        n_cmp++;
        if (t_fall != (HA + HF + 1) * CD) begin
            n_bad++;
            $display("FAIL hs_first_fall got=%0d want=%0d", t_fall, (HA + HF + 1) * CD);
        end
        guard = 0;
        while (vga_hs !== 1'b1 && guard < 2000) begin step(); guard++; end
        t_rise = ecnt;
        n_cmp++;
        if (t_rise - t_fall != HSY * CD) begin
            n_bad++;
            $display("FAIL hs_width got=%0d want=%0d", t_rise - t_fall, HSY * CD);
        end
        guard = 0;
        while (vga_hs !== 1'b0 && guard < 2000) begin step(); guard++; end
        n_cmp++;
        if (ecnt - t_fall != HT * CD) begin
            n_bad++;
            $display("FAIL hs_period got=%0d want=%0d", ecnt - t_fall, HT * CD);
        end
    endtask

    task automatic test_frame_timing();
        int guard;
        int unsigned t_fall, t_rise;
        logic prev_vs;
        do_reset();
        prev_vs = 1'b1;
        t_fall = 0;
        t_rise = 0;
        guard = 0;
        // Walk one full frame plus the next vs fall, checking every clock.
        while (guard < 3 * VT * HT * CD) begin
            run_compare(1, "frame_walk");
            guard++;
            if (prev_vs === 1'b1 && vga_vs === 1'b0) begin
                if (t_fall != 0) break;
                t_fall = ecnt;
            end
            if (prev_vs === 1'b0 && vga_vs === 1'b1 && t_fall != 0) t_rise = ecnt;
            prev_vs = vga_vs;
        end
        n_cmp++;
        if (t_rise - t_fall != VSY * HT * CD) begin
            n_bad++;
            $display("FAIL vs_width got=%0d want=%0d", t_rise - t_fall, VSY * HT * CD);
        end
        n_cmp++;
        if (ecnt - t_fall != VT * HT * CD) begin
            n_bad++;
            $display("FAIL vs_period got=%0d want=%0d", ecnt - t_fall, VT * HT * CD);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int it = 0; it < 3; it++) begin
            run_compare($urandom_range(200, 2500), "pre_reset");
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (obs() !== RST_OUT) begin
                n_bad++;
                $display("FAIL async_reset got=%h want=%h", obs(), RST_OUT);
            end
            repeat ($urandom_range(1, 4)) begin
                step();
                n_cmp++;
                if (obs() !== RST_OUT) begin
                    n_bad++;
                    $display("FAIL reset_held got=%h want=%h", obs(), RST_OUT);
                end
            end
            @(negedge clk);
            rst_n = 1'b1;
            run_compare($urandom_range(50, 600), "post_reset");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_fixed_pixels();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
